// File: rtl/dnc_write_heads_multi.sv
// DNC write-head interface conditioner: for each of H heads, accepts one scalar
// triple and W vector elements, clamps gates, offsets strength, and echoes key/value.
module dnc_write_heads_multi #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int H            = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
  input  logic                    SCALAR_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    GA_IN,
  input  logic [DATA_SIZE-1:0]    GW_IN,
  input  logic [DATA_SIZE-1:0]    BETA_IN,
  input  logic                    VECTOR_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    K_IN,
  input  logic [DATA_SIZE-1:0]    E_IN,
  input  logic [DATA_SIZE-1:0]    V_IN,
  output logic [DATA_SIZE-1:0]    GA_OUT,
  output logic [DATA_SIZE-1:0]    GW_OUT,
  output logic [DATA_SIZE-1:0]    BETA_OUT,
  output logic                    SCALAR_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    K_OUT,
  output logic [DATA_SIZE-1:0]    E_OUT,
  output logic [DATA_SIZE-1:0]    V_OUT,
  output logic                    VECTOR_OUT_ENABLE,
  output logic [CONTROL_SIZE-1:0] HEAD_OUT
);

  localparam int FRAC = DATA_SIZE / 2;
  localparam logic [DATA_SIZE-1:0] ONE     = {{(DATA_SIZE-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [DATA_SIZE-1:0] MAX_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SCALAR, VECTOR, NEXT} state_t;

  state_t                  state;
  logic [CONTROL_SIZE-1:0] size_w;
  logic [CONTROL_SIZE-1:0] head;
  logic [CONTROL_SIZE-1:0] elem;
  logic                    last_head;
  logic                    last_elem;

  // Gates live in [0, ONE]; the sign bit alone identifies negative inputs.
  function automatic logic [DATA_SIZE-1:0] gate_clamp(input logic [DATA_SIZE-1:0] x);
    if (x[DATA_SIZE-1])
      return '0;
    else if (x > ONE)
      return ONE;
    else
      return x;
  endfunction

  // Non-negative x plus ONE cannot wrap the full word, so a set sign bit means overflow.
  function automatic logic [DATA_SIZE-1:0] strength(input logic [DATA_SIZE-1:0] x);
    logic [DATA_SIZE-1:0] sum;
    sum = x + ONE;
    if (x[DATA_SIZE-1])
      return ONE;
    else if (sum[DATA_SIZE-1])
      return MAX_POS;
    else
      return sum;
  endfunction

  assign last_head = (head == CONTROL_SIZE'(H - 1));
  assign last_elem = (elem == size_w - CONTROL_SIZE'(1));

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order within the block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      READY             <= 1'b1;
      size_w            <= '0;
      head              <= '0;
      elem              <= '0;
      GA_OUT            <= '0;
      GW_OUT            <= '0;
      BETA_OUT          <= '0;
      SCALAR_OUT_ENABLE <= 1'b0;
      K_OUT             <= '0;
      E_OUT             <= '0;
      V_OUT             <= '0;
      VECTOR_OUT_ENABLE <= 1'b0;
      HEAD_OUT          <= '0;
    end else begin
      SCALAR_OUT_ENABLE <= 1'b0;
      VECTOR_OUT_ENABLE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            size_w <= SIZE_W_IN;
            head   <= '0;
            elem   <= '0;
            READY  <= 1'b0;
            state  <= SCALAR;
          end
        end
        SCALAR: begin
          if (SCALAR_IN_ENABLE) begin
            GA_OUT            <= gate_clamp(GA_IN);
            GW_OUT            <= gate_clamp(GW_IN);
            BETA_OUT          <= strength(BETA_IN);
            SCALAR_OUT_ENABLE <= 1'b1;
            HEAD_OUT          <= head;
            if (size_w == '0) begin
              state <= NEXT;
              if (last_head) READY <= 1'b1;
            end else begin
              state <= VECTOR;
            end
          end
        end
        VECTOR: begin
          if (VECTOR_IN_ENABLE) begin
            K_OUT             <= K_IN;
            E_OUT             <= gate_clamp(E_IN);
            V_OUT             <= V_IN;
            VECTOR_OUT_ENABLE <= 1'b1;
            HEAD_OUT          <= head;
            if (last_elem) begin
              state <= NEXT;
              if (last_head) READY <= 1'b1;
            end else begin
              elem <= elem + CONTROL_SIZE'(1);
            end
          end
        end
        NEXT: begin
          if (last_head) begin
            state <= IDLE;
          end else begin
            head  <= head + CONTROL_SIZE'(1);
            elem  <= '0;
            state <= SCALAR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnc_write_heads_multi.sv
// Self-checking bench for dnc_write_heads_multi (16-bit data, two heads):
// directed corner values plus randomized jobs against an arithmetic reference.
module tb_dnc_write_heads_multi;

  localparam int DS = 16;
  localparam int CS = 16;
  localparam int HH = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          READY;
  logic [CS-1:0] SIZE_W_IN;
  logic          SCALAR_IN_ENABLE;
  logic [DS-1:0] GA_IN, GW_IN, BETA_IN;
  logic          VECTOR_IN_ENABLE;
  logic [DS-1:0] K_IN, E_IN, V_IN;
  logic [DS-1:0] GA_OUT, GW_OUT, BETA_OUT;
  logic          SCALAR_OUT_ENABLE;
  logic [DS-1:0] K_OUT, E_OUT, V_OUT;
  logic          VECTOR_OUT_ENABLE;
  logic [CS-1:0] HEAD_OUT;

  dnc_write_heads_multi #(.DATA_SIZE(DS), .CONTROL_SIZE(CS), .H(HH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIZE_W_IN(SIZE_W_IN),
    .SCALAR_IN_ENABLE(SCALAR_IN_ENABLE), .GA_IN(GA_IN), .GW_IN(GW_IN), .BETA_IN(BETA_IN),
    .VECTOR_IN_ENABLE(VECTOR_IN_ENABLE), .K_IN(K_IN), .E_IN(E_IN), .V_IN(V_IN),
    .GA_OUT(GA_OUT), .GW_OUT(GW_OUT), .BETA_OUT(BETA_OUT), .SCALAR_OUT_ENABLE(SCALAR_OUT_ENABLE),
    .K_OUT(K_OUT), .E_OUT(E_OUT), .V_OUT(V_OUT), .VECTOR_OUT_ENABLE(VECTOR_OUT_ENABLE),
    .HEAD_OUT(HEAD_OUT)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int vout_count  = 0;

  // Running tally of vector output pulses, sampled mid-cycle.
  always @(negedge CLK) if (VECTOR_OUT_ENABLE === 1'b1) vout_count++;

  // Expected output register contents (they hold between enables).
  logic [DS-1:0] exp_ga, exp_gw, exp_beta, exp_k, exp_e, exp_v;
  logic [CS-1:0] exp_head;

  function automatic logic [DS-1:0] m_gate(input logic [DS-1:0] x);
    int v = $signed(x);
    if (v < 0) return 16'h0000;
    if (v > 256) return 16'h0100;
    return x;
  endfunction

  function automatic logic [DS-1:0] m_beta(input logic [DS-1:0] x);
    int v = $signed(x);
    int s;
    if (v < 0) return 16'h0100;
    s = 256 + v;
    return (s > 32767) ? 16'h7FFF : 16'(s);
  endfunction

  function automatic logic [DS-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0100;
      2: return 16'h0101;
      3: return 16'h8000;
      4: return 16'h7FFF;
      5: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic soe, input logic voe, input logic rdy);
    check({tag, ".soe"},   64'(SCALAR_OUT_ENABLE), 64'(soe));
    check({tag, ".voe"},   64'(VECTOR_OUT_ENABLE), 64'(voe));
    check({tag, ".ready"}, 64'(READY),             64'(rdy));
    check({tag, ".ga"},    64'(GA_OUT),            64'(exp_ga));
    check({tag, ".gw"},    64'(GW_OUT),            64'(exp_gw));
    check({tag, ".beta"},  64'(BETA_OUT),          64'(exp_beta));
    check({tag, ".k"},     64'(K_OUT),             64'(exp_k));
    check({tag, ".e"},     64'(E_OUT),             64'(exp_e));
    check({tag, ".v"},     64'(V_OUT),             64'(exp_v));
    check({tag, ".head"},  64'(HEAD_OUT),          64'(exp_head));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_exp();
    exp_ga = '0; exp_gw = '0; exp_beta = '0;
    exp_k  = '0; exp_e  = '0; exp_v    = '0;
    exp_head = '0;
  endtask

  // One START..done job. directed selects corner-case scalar/erase values;
  // stray injects ignored enables and START pulses; abort resets during head 1.
  task automatic run_job(input int w, input bit directed, input bit stray, input bit abort);
    int base = vout_count;
    START = 1'b1; SIZE_W_IN = CS'(w);
    step();
    START = 1'b0; SIZE_W_IN = CS'($urandom);
    check_all("start", 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < HH; h++) begin
      int gaps = (h == 0 ? 0 : 1) + int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        if (stray) begin VECTOR_IN_ENABLE = 1'b1; START = 1'b1; end
        K_IN = rnd_val(); E_IN = rnd_val(); V_IN = rnd_val();
        step();
        VECTOR_IN_ENABLE = 1'b0; START = 1'b0;
        check_all("gap_s", 1'b0, 1'b0, 1'b0);
      end
      GA_IN = rnd_val(); GW_IN = rnd_val(); BETA_IN = rnd_val();
      if (directed) begin
        if (h == 0) begin GA_IN = 16'h0080; GW_IN = 16'h0300; end
        BETA_IN = (w == 0) ? 16'h0050 : (h == 0 ? 16'hFF00 : 16'h7FF0);
      end
      SCALAR_IN_ENABLE = 1'b1;
      step();
      SCALAR_IN_ENABLE = 1'b0;
      exp_ga = m_gate(GA_IN); exp_gw = m_gate(GW_IN); exp_beta = m_beta(BETA_IN);
      exp_head = CS'(h);
      check_all("scalar", 1'b1, 1'b0, (w == 0) && (h == HH - 1));
      for (int e = 0; e < w; e++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (stray) SCALAR_IN_ENABLE = 1'b1;
          GA_IN = rnd_val();
          step();
          SCALAR_IN_ENABLE = 1'b0;
          check_all("gap_v", 1'b0, 1'b0, 1'b0);
        end
        K_IN = rnd_val(); E_IN = rnd_val(); V_IN = rnd_val();
        if (directed) E_IN = (e == 0) ? 16'hFFFF : (e == 1 ? 16'h0040 : 16'h0200);
        VECTOR_IN_ENABLE = 1'b1;
        step();
        VECTOR_IN_ENABLE = 1'b0;
        exp_k = K_IN; exp_e = m_gate(E_IN); exp_v = V_IN;
        check_all("vector", 1'b0, 1'b1, (e == w - 1) && (h == HH - 1));
        if (abort && h == 1 && e == 0) begin
          RST = 1'b1; VECTOR_IN_ENABLE = 1'b1; SCALAR_IN_ENABLE = 1'b1;
          step();
          RST = 1'b0; VECTOR_IN_ENABLE = 1'b0; SCALAR_IN_ENABLE = 1'b0;
          clear_exp();
          check_all("reset_mid", 1'b0, 1'b0, 1'b1);
          return;
        end
      end
    end
    step();
    check_all("done", 1'b0, 1'b0, 1'b1);
    check("vout_count", 64'(vout_count - base), 64'(HH * w));
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; SIZE_W_IN = '0;
    SCALAR_IN_ENABLE = 1'b0; VECTOR_IN_ENABLE = 1'b0;
    GA_IN = '0; GW_IN = '0; BETA_IN = '0; K_IN = '0; E_IN = '0; V_IN = '0;
    clear_exp();
    step();
    START = 1'b1; VECTOR_IN_ENABLE = 1'b1;
    step();
    START = 1'b0; VECTOR_IN_ENABLE = 1'b0;
    check_all("reset", 1'b0, 1'b0, 1'b1);
    RST = 1'b0;

    run_job(3, 1'b1, 1'b0, 1'b0);
    run_job(0, 1'b1, 1'b1, 1'b0);
    run_job(2, 1'b0, 1'b1, 1'b1);
    run_job(3, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) run_job(int'($urandom_range(0, 4)), 1'b0, 1'b1, 1'b0);
    run_job(1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
